// File: rtl/mimo_job_scheduler.sv
// Round-robin scheduler that shares one MIMO detector among NUM_REQ requesters and guards each job with a watchdog.
// Optional statistics counters are built only when the STATS_EN macro is defined.
module mimo_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*5-1:0]         req_cfg,
  input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
  output logic                         det_start,
  output logic [4:0]                   det_cfg,
  input  logic                         det_done,
  output logic                         det_abort,
  output logic                         cmp_valid,
  input  logic                         cmp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   cmp_src,
  output logic [TAG_W-1:0]             cmp_tag,
  output logic [1:0]                   cmp_err,
  output logic [CNT_W-1:0]             stat_jobs,
  output logic [CNT_W-1:0]             stat_errs,
  output logic [1:0]                   dbg_state
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t            state;
  logic [SRC_W-1:0]  last_grant;
  logic [SRC_W-1:0]  grant_idx;
  logic [TMR_W-1:0]  timer;
  logic [4:0]        sel_cfg;
  logic [TAG_W-1:0]  sel_tag;
  logic              any_req;
  logic              timeout_hit;

  function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SRC_W'(s);
  endfunction

  // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    grant_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[rr_index(last_grant, k)]) grant_idx = rr_index(last_grant, k);
    end
  end

  always_comb begin
    sel_cfg = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_cfg = req_cfg[5*i +: 5];
        sel_tag = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  assign any_req   = |req_valid;
  assign req_ready = (state == IDLE && any_req) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign dbg_state = state;

  // Abort is decoded in the deciding cycle so a simultaneous det_done can suppress it.
  assign timeout_hit = (state == WAIT) && (timer == TMR_LAST) && !det_done;
  assign det_abort   = timeout_hit;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high; cmp_valid,
  // once raised, holds with cmp_src/cmp_tag/cmp_err stable until that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_W'(NUM_REQ - 1);
      timer      <= '0;
      det_start  <= 1'b0;
      det_cfg    <= '0;
      cmp_valid  <= 1'b0;
      cmp_src    <= '0;
      cmp_tag    <= '0;
      cmp_err    <= 2'b00;
    end else begin
      det_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cmp_src <= grant_idx;
            cmp_tag <= sel_tag;
            det_cfg <= sel_cfg;
            if (sel_cfg[1:0] == 2'b11) begin
              cmp_err   <= 2'b10;
              cmp_valid <= 1'b1;
              state     <= REPORT;
            end else begin
              det_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (det_done) begin
            cmp_err   <= 2'b00;
            cmp_valid <= 1'b1;
            state     <= REPORT;
          end else if (timer == TMR_LAST) begin
            cmp_err   <= 2'b01;
            cmp_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        REPORT: begin
          if (cmp_ready) begin
            cmp_valid  <= 1'b0;
            last_grant <= cmp_src;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_jobs <= '0;
      stat_errs <= '0;
    end else if (state == REPORT && cmp_ready) begin
      if (cmp_err == 2'b00) begin
        if (stat_jobs != '1) stat_jobs <= stat_jobs + CNT_W'(1);
      end else begin
        if (stat_errs != '1) stat_errs <= stat_errs + CNT_W'(1);
      end
    end
  end
`else
  assign stat_jobs = '0;
  assign stat_errs = '0;
`endif

endmodule

// File: tb/tb_mimo_job_scheduler.sv
// Directed bench for mimo_job_scheduler: an event-timeline model checks every cycle, and
// literal expectations per scenario pin the model's grant order, latencies and records.
`timescale 1ns/1ps
module tb_mimo_job_scheduler;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 8;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;
  localparam int SRC_W   = $clog2(NUM_REQ);
  localparam int REC_W   = SRC_W + TAG_W + 2;
`ifdef STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*5-1:0]     req_cfg = '0;
  logic [NUM_REQ*TAG_W-1:0] req_tag = '0;
  logic                     det_start;
  logic [4:0]               det_cfg;
  logic                     det_done = 1'b0;
  logic                     det_abort;
  logic                     cmp_valid;
  logic                     cmp_ready = 1'b1;
  logic [SRC_W-1:0]         cmp_src;
  logic [TAG_W-1:0]         cmp_tag;
  logic [1:0]               cmp_err;
  logic [CNT_W-1:0]         stat_jobs;
  logic [CNT_W-1:0]         stat_errs;
  logic [1:0]               dbg_state;

  mimo_job_scheduler #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cfg(req_cfg),
    .req_tag(req_tag), .det_start(det_start), .det_cfg(det_cfg), .det_done(det_done),
    .det_abort(det_abort), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_src(cmp_src),
    .cmp_tag(cmp_tag), .cmp_err(cmp_err), .stat_jobs(stat_jobs), .stat_errs(stat_errs),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_delay = -1;

  // ---------------- scoreboard and model ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] c_rec_q[$];
  int g_src_q[$], g_cyc_q[$], s_cyc_q[$], a_cyc_q[$], c_cyc_q[$];

  bit               m_busy;
  int               m_src, m_start_at, m_report_at, m_last, m_jobs, m_errs;
  logic [TAG_W-1:0] m_tag;
  logic [1:0]       m_err;
  logic [4:0]       m_cfg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] rv, input int last);
    int r = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r < 0 && rv[(last + k) % NUM_REQ]) r = (last + k) % NUM_REQ;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = NUM_REQ - 1; m_cfg = '0; m_jobs = 0; m_errs = 0;
    m_start_at = -1; m_report_at = -1;
    exp_q.delete();
  endtask

  task automatic monitor_cycle();
    logic [NUM_REQ-1:0] exp_ready = '0;
    logic [REC_W-1:0]   exp_rec;
    int g = -1;
    bit waiting, exp_start, exp_abort, exp_valid;
    if (!m_busy && |req_valid) begin
      g = pick(req_valid, m_last);
      exp_ready[g] = 1'b1;
    end
    waiting   = m_busy && m_start_at >= 0 && m_report_at < 0 &&
                cyc > m_start_at && cyc <= m_start_at + TIMEOUT;
    exp_start = m_busy && cyc == m_start_at;
    exp_abort = waiting && cyc == m_start_at + TIMEOUT && !det_done;
    exp_valid = m_busy && m_report_at >= 0 && cyc >= m_report_at;

    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("det_start", 32'(det_start), 32'(exp_start));
    check("det_abort", 32'(det_abort), 32'(exp_abort));
    check("det_cfg", 32'(det_cfg), 32'(m_cfg));
    check("cmp_valid", 32'(cmp_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("cmp_src", 32'(cmp_src), m_src);
      check("cmp_tag", 32'(cmp_tag), 32'(m_tag));
      check("cmp_err", 32'(cmp_err), 32'(m_err));
    end
    check("stat_jobs", 32'(stat_jobs), STATS_ON ? m_jobs : 0);
    check("stat_errs", 32'(stat_errs), STATS_ON ? m_errs : 0);

    if (exp_start) s_cyc_q.push_back(cyc);
    if (waiting && (det_done || cyc == m_start_at + TIMEOUT)) begin
      m_err = det_done ? 2'b00 : 2'b01;
      if (!det_done) a_cyc_q.push_back(cyc);
      m_report_at = cyc + 1;
      exp_q.push_back({SRC_W'(m_src), m_tag, m_err});
    end
    if (exp_valid && cmp_ready) begin
      check("cmp_expected_present", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_rec = exp_q.pop_front();
        check("cmp_record", 32'({cmp_src, cmp_tag, cmp_err}), 32'(exp_rec));
        c_rec_q.push_back(exp_rec);
        c_cyc_q.push_back(cyc);
      end
      if (m_err == 2'b00) begin
        if (m_jobs < (1 << CNT_W) - 1) m_jobs++;
      end else if (m_errs < (1 << CNT_W) - 1) m_errs++;
      m_last = m_src;
      m_busy = 0;
    end
    if (g >= 0) begin
      m_busy = 1; m_src = g;
      m_cfg  = req_cfg[5*g +: 5];
      m_tag  = req_tag[TAG_W*g +: TAG_W];
      g_src_q.push_back(g); g_cyc_q.push_back(cyc);
      if (m_cfg[1:0] == 2'b11) begin
        m_err = 2'b10; m_start_at = -1; m_report_at = cyc + 1;
        exp_q.push_back({SRC_W'(m_src), m_tag, m_err});
      end else begin
        m_start_at = cyc + 1; m_report_at = -1;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) model_reset();
    else monitor_cycle();
  end

  // Detector stand-in: answers each start after done_delay cycles, or never when negative.
  initial begin
    forever begin
      @(negedge clk);
      if (det_start && done_delay >= 0) begin
        repeat (done_delay) @(posedge clk);
        #1 det_done = 1'b1;
        @(posedge clk);
        #1 det_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    g_src_q.delete(); g_cyc_q.delete(); s_cyc_q.delete();
    a_cyc_q.delete(); c_cyc_q.delete(); c_rec_q.delete();
  endtask

  task automatic set_req(input int i, input logic [4:0] cfg, input logic [TAG_W-1:0] tag);
    req_cfg[5*i +: 5]         = cfg;
    req_tag[TAG_W*i +: TAG_W] = tag;
    req_valid[i]              = 1'b1;
  endtask

  task automatic wait_grants(input int n);
    int k = 0;
    while (g_src_q.size() < n && k < 200) begin @(posedge clk); k++; end
    #1;
    check("wait_grants", 32'(g_src_q.size() >= n), 1);
  endtask

  task automatic wait_cmps(input int n);
    int k = 0;
    while (c_rec_q.size() < n && k < 200) begin @(posedge clk); k++; end
    #1;
    check("wait_cmps", 32'(c_rec_q.size() >= n), 1);
  endtask

  task automatic wait_cmp_valid();
    int k = 0;
    while (!cmp_valid && k < 200) begin @(posedge clk); #1; k++; end
    check("wait_cmp_valid", 32'(cmp_valid), 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    tick(2);
    check("reset_state", 32'(dbg_state), 0);
    check("reset_cmp_valid", 32'(cmp_valid), 0);
    check("reset_det_cfg", 32'(det_cfg), 0);
    rst = 1'b0;

    // Single job with detector answering two cycles after start.
    done_delay = 2; cmp_ready = 1'b1; clear_logs();
    set_req(0, 5'b010_01, 8'h3C);
    wait_grants(1);
    req_valid = '0;
    wait_cmps(1);
    check("t1_grant_src", g_src_q[0], 0);
    check("t1_start_latency", s_cyc_q[0] - g_cyc_q[0], 1);
    check("t1_det_cfg", 32'(det_cfg), 32'h09);
    check("t1_record", 32'(c_rec_q[0]), 32'({2'd0, 8'h3C, 2'b00}));
    check("t1_cmp_latency", c_cyc_q[0] - g_cyc_q[0], 4);

    // Four requesters held valid: grants rotate 0,1,2,3,0.
    do_reset(); done_delay = 1; clear_logs();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, {i[2:0], 2'b01}, 8'hA0 + 8'(i));
    wait_grants(5);
    req_valid = '0;
    wait_cmps(5);
    for (int k = 0; k < 5; k++) begin
      check("t2_grant_order", g_src_q[k], exp_order[k]);
      check("t2_record", 32'(c_rec_q[k]),
            32'({SRC_W'(exp_order[k]), 8'hA0 + 8'(exp_order[k]), 2'b00}));
    end

    // Watchdog timeout.
    do_reset(); done_delay = -1; clear_logs();
    set_req(1, 5'b100_10, 8'h55);
    wait_grants(1);
    req_valid = '0;
    wait_cmps(1);
    check("t3_abort_seen", a_cyc_q.size(), 1);
    if (a_cyc_q.size() > 0) check("t3_abort_delay", a_cyc_q[0] - s_cyc_q[0], 8);
    check("t3_record", 32'(c_rec_q[0]), 32'({2'd1, 8'h55, 2'b01}));
    check("t3_stat_errs", 32'(stat_errs), STATS_ON);

    // Invalid detection mode skips the detector.
    clear_logs();
    set_req(2, 5'b011_11, 8'h77);
    wait_grants(1);
    req_valid = '0;
    wait_cmps(1);
    check("t4_no_start", s_cyc_q.size(), 0);
    check("t4_cmp_latency", c_cyc_q[0] - g_cyc_q[0], 1);
    check("t4_record", 32'(c_rec_q[0]), 32'({2'd2, 8'h77, 2'b10}));
    check("t4_det_cfg", 32'(det_cfg), 32'h0F);

    // Backpressure with done arriving on the timeout cycle.
    do_reset(); done_delay = TIMEOUT; cmp_ready = 1'b0; clear_logs();
    set_req(3, 5'b001_01, 8'h9A);
    wait_grants(1);
    req_valid = '0;
    set_req(0, 5'b000_00, 8'h11);
    wait_cmp_valid();
    for (int k = 0; k < 5; k++) begin
      check("t5_record_stable", 32'({cmp_src, cmp_tag, cmp_err}), 32'({2'd3, 8'h9A, 2'b00}));
      check("t5_no_ready", 32'(req_ready), 0);
      tick(1);
    end
    cmp_ready = 1'b1;
    wait_cmps(1);
    wait_grants(2);
    req_valid = '0;
    check("t5_no_abort", a_cyc_q.size(), 0);
    check("t5_next_grant", g_src_q[1], 0);
    check("t5_regrant_gap", g_cyc_q[1] - c_cyc_q[0], 1);
    wait_cmps(2);

    // Reset while a job waits on the detector.
    do_reset(); done_delay = 1; clear_logs();
    set_req(1, 5'b001_00, 8'h21);
    wait_grants(1);
    req_valid = '0;
    wait_cmps(1);
    done_delay = -1;
    set_req(3, 5'b010_10, 8'h23);
    wait_grants(2);
    req_valid = '0;
    tick(3);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_state", 32'(dbg_state), 0);
    check("t6_rst_outputs", 32'({req_ready, det_start, det_abort, cmp_valid, cmp_err}), 0);
    check("t6_rst_fields", 32'({det_cfg, cmp_src, cmp_tag}), 0);
    check("t6_rst_stats", 32'({stat_jobs, stat_errs}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    done_delay = 1; clear_logs();
    set_req(2, 5'b011_01, 8'h32);
    set_req(0, 5'b000_01, 8'h30);
    wait_grants(1);
    req_valid[0] = 1'b0;
    check("t6_first_after_reset", g_src_q[0], 0);
    wait_grants(2);
    req_valid = '0;
    check("t6_second_after_reset", g_src_q[1], 2);
    wait_cmps(2);
    check("t6_records", 32'({c_rec_q[0], c_rec_q[1]}),
          32'({2'd0, 8'h30, 2'b00, 2'd2, 8'h32, 2'b00}));
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
